// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   arb_state_e : controller FSM states
//   RW_*        : ram_rw / mem_rw encodings
//   OWNER_*     : grant owner encodings
//   lanes_of()  : byte-lane count for a given data width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  function automatic int unsigned lanes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selector for the memory arbiter.
// Data wins by default. Fetch wins when it is the only requester, or when
// both request and data has already taken STARVE_MAX grants in a row while
// fetch was waiting.
//   clock, reset : system clock, synchronous active-high reset
//   if_req       : fetch request
//   mem_req      : data request
//   grant        : a grant is being made this cycle (updates the streak)
//   owner        : OWNER_IF / OWNER_MEM choice for this cycle (combinational)
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic mem_req,
  input  logic grant,
  output logic owner
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(STARVE_MAX);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    owner = OWNER_MEM;
    if (if_req && (!mem_req || (streak_q == STREAK_CAP))) begin
      owner = OWNER_IF;
    end
  end

  // Streak only grows while fetch is actually being held off; any fetch grant
  // or an uncontended data grant restarts it.
  always_comb begin
    streak_d = streak_q;
    if (grant) begin
      if ((owner == OWNER_MEM) && if_req) begin
        if (streak_q != STREAK_CAP) begin
          streak_d = streak_q + SW'(1);
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Fetch/data arbiter onto one single-port byte-lane RAM.
// Each access runs IDLE -> ISSUE -> WAIT (WAIT_CYC cycles) -> RESP, with a
// one-cycle ack pulse to the owner in RESP. Data accesses with no byte
// enables skip the RAM and go straight to RESP.
//   clock, reset              : system clock, synchronous active-high reset
//   if_req/if_addr            : fetch request (read-only, full word)
//   if_ack/if_rdata           : fetch completion pulse / held fetched word
//   mem_req/rw/addr/be/wdata  : data request
//   mem_ack/mem_rdata         : data completion pulse / held masked read data
//   ram_en/rw/addr/be/wdata   : RAM strobe and command (strobe only in ISSUE)
//   ram_rdata                 : RAM read data
//   busy                      : high whenever not IDLE
module mem_arb_ctrl
  import mem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned WAIT_CYC   = 1,
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned LANES      = lanes_of(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LANES-1:0]  mem_be,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LANES-1:0]  ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic grant;
  logic sel_owner;
  logic capture;

  mem_arb_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clock   (clock),
    .reset   (reset),
    .if_req  (if_req),
    .mem_req (mem_req),
    .grant   (grant),
    .owner   (sel_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    wcnt_d      = wcnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    grant       = 1'b0;
    capture     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          grant   = 1'b1;
          owner_d = sel_owner;
          if (sel_owner == OWNER_IF) begin
            addr_d  = if_addr;
            rw_d    = RW_READ;
            be_d    = '1;
            wdata_d = '0;
            state_d = ISSUE;
          end else begin
            addr_d  = mem_addr;
            rw_d    = mem_rw;
            be_d    = mem_be;
            wdata_d = mem_wdata;
            if (mem_be == '0) begin
              // No lanes enabled: complete without touching the RAM.
              state_d = RESP;
              if (mem_rw == RW_READ) begin
                mem_rdata_d = '0;
              end
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (WAIT_CYC > 0) begin
          wcnt_d  = WAIT_INIT;
          state_d = WAIT;
        end else begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          state_d = RESP;
          capture = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture && (rw_q == RW_READ)) begin
      if (owner_q == OWNER_IF) begin
        if_rdata_d = ram_rdata;
      end else begin
        for (int unsigned i = 0; i < LANES; i++) begin
          mem_rdata_d[8*i +: 8] = be_q[i] ? ram_rdata[8*i +: 8] : 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      addr_q      <= '0;
      rw_q        <= RW_READ;
      be_q        <= '0;
      wdata_q     <= '0;
      wcnt_q      <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      wcnt_q      <= wcnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_en    = (state_q == ISSUE);
  assign ram_rw    = rw_q;
  assign ram_addr  = addr_q;
  assign ram_be    = be_q;
  assign ram_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) && (owner_q == OWNER_IF);
  assign mem_ack   = (state_q == RESP) && (owner_q == OWNER_MEM);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
